// File: rtl/ddr3_arb_pkg.sv
// Purpose: shared types and widths for the two-master DDR3 EMIF arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, read tag {owner, burst}, EMIF bus widths,
//           burstcount normalisation helper.
package ddr3_arb_pkg;

    localparam int ADDR_W  = 22;
    localparam int DATA_W  = 256;
    localparam int BE_W    = 32;
    localparam int BURST_W = 5;

    localparam logic [BURST_W-1:0] ONE_BEAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_WR_BURST = 2'd2
    } arb_state_t;

    // One entry per outstanding read command: who issued it and how many
    // beats the EMIF will return for it.
    typedef struct packed {
        logic               owner;
        logic [BURST_W-1:0] burst;
    } rd_tag_t;

    // A burstcount of zero is treated as a single beat.
    function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] bc);
        return (bc == '0) ? ONE_BEAT : bc;
    endfunction

endpackage

// File: rtl/ddr3_arb_tag_fifo.sv
// Purpose: synchronous DEPTH-entry FIFO of read tags (owner + burst length).
// Latency: push visible at dout the cycle after the write; dout is the live head.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
// Ports: clk/rst (async active-high), push/din, pop, dout (head), full, empty.
module ddr3_arb_tag_fifo
    import ddr3_arb_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  rd_tag_t din,
    input  logic    pop,
    output rd_tag_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    rd_tag_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    // DEPTH is a power of two, so the count MSB alone flags full.
    assign full    = count[AW];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_emif_arbiter.sv
// Purpose: arbitrates two Avalon-MM masters onto one DDR3 EMIF port, routes read data back by tag.
// Latency: command presented to EMIF one cycle after request; read data returned combinationally.
// Backpressure: granted master sees ~ddr3_emif_ready (plus tag-FIFO full for reads); others wait.
// Ports: m0_*/m1_* Avalon-MM slaves, ddr3_emif_* master side, err_orphan_rd sticky error.
// Config: define DDR3_ARB_FIXED_PRIO_EN for fixed m0 priority; default is round-robin.
module ddr3_emif_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int TAG_DEPTH = 8
)
(
    input  logic               ddr3_emif_clk,
    input  logic               ddr3_emif_rst,
    // requester 0
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [ADDR_W-1:0]  m0_addr,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic [DATA_W-1:0]  m0_writedata,
    input  logic [BE_W-1:0]    m0_byteenable,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,
    // requester 1
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [ADDR_W-1:0]  m1_addr,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic [DATA_W-1:0]  m1_writedata,
    input  logic [BE_W-1:0]    m1_byteenable,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,
    // EMIF
    input  logic               ddr3_emif_ready,
    input  logic [DATA_W-1:0]  ddr3_emif_read_data,
    input  logic               ddr3_emif_rddata_valid,
    output logic               ddr3_emif_read,
    output logic               ddr3_emif_write,
    output logic [ADDR_W-1:0]  ddr3_emif_addr,
    output logic [DATA_W-1:0]  ddr3_emif_write_data,
    output logic [BE_W-1:0]    ddr3_emif_byte_enable,
    output logic [BURST_W-1:0] ddr3_emif_burst_count,
    output logic               err_orphan_rd
);

    arb_state_t         state, state_nxt;
    logic               gnt, gnt_nxt;
    logic [BURST_W-1:0] wr_cnt, wr_cnt_nxt;
    logic [BURST_W-1:0] ret_cnt;
    logic               cmd_done;
    logic               wait_g;

    logic               req0, req1, win;
    logic               g_read, g_write;
    logic [ADDR_W-1:0]  g_addr;
    logic [BURST_W-1:0] g_bc_eff;
    logic [DATA_W-1:0]  g_wdata;
    logic [BE_W-1:0]    g_be;

    logic               tag_push, tag_pop, tag_full, tag_empty, head_last;
    rd_tag_t            tag_din, head;

    assign req0     = m0_read | m0_write;
    assign req1     = m1_read | m1_write;
    assign g_read   = gnt ? m1_read       : m0_read;
    assign g_write  = gnt ? m1_write      : m0_write;
    assign g_addr   = gnt ? m1_addr       : m0_addr;
    assign g_wdata  = gnt ? m1_writedata  : m0_writedata;
    assign g_be     = gnt ? m1_byteenable : m0_byteenable;
    assign g_bc_eff = eff_burst(gnt ? m1_burstcount : m0_burstcount);

`ifdef DDR3_ARB_FIXED_PRIO_EN
    // m0 wins whenever it is requesting.
    assign win = ~req0;
`else
    logic rr_ptr;

    // On contention the pointer picks the winner; it moves to the other
    // master after every command the EMIF accepts.
    assign win = (req0 & req1) ? rr_ptr : req1;

    always_ff @(posedge ddr3_emif_clk or posedge ddr3_emif_rst) begin
        if (ddr3_emif_rst)  rr_ptr <= 1'b0;
        else if (cmd_done)  rr_ptr <= ~gnt;
    end
`endif

    always_comb begin
        state_nxt             = state;
        gnt_nxt               = gnt;
        wr_cnt_nxt            = wr_cnt;
        cmd_done              = 1'b0;
        tag_push              = 1'b0;
        wait_g                = 1'b1;
        ddr3_emif_read        = 1'b0;
        ddr3_emif_write       = 1'b0;
        ddr3_emif_addr        = '0;
        ddr3_emif_write_data  = '0;
        ddr3_emif_byte_enable = '0;
        ddr3_emif_burst_count = '0;

        case (state)
            ST_IDLE: begin
                if (req0 | req1) begin
                    gnt_nxt   = win;
                    state_nxt = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (!(g_read | g_write)) begin
                    // Requester withdrew before acceptance.
                    state_nxt = ST_IDLE;
                end else if (g_read) begin
                    // Hold the read off the EMIF entirely while no tag slot is free,
                    // so every issued read is always tracked.
                    ddr3_emif_read        = ~tag_full;
                    ddr3_emif_addr        = g_addr;
                    ddr3_emif_burst_count = g_bc_eff;
                    wait_g                = tag_full | ~ddr3_emif_ready;
                    if (!tag_full && ddr3_emif_ready) begin
                        tag_push  = 1'b1;
                        cmd_done  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    ddr3_emif_write       = 1'b1;
                    ddr3_emif_addr        = g_addr;
                    ddr3_emif_write_data  = g_wdata;
                    ddr3_emif_byte_enable = g_be;
                    ddr3_emif_burst_count = g_bc_eff;
                    wait_g                = ~ddr3_emif_ready;
                    if (ddr3_emif_ready) begin
                        cmd_done = 1'b1;
                        if (g_bc_eff == ONE_BEAT) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            wr_cnt_nxt = g_bc_eff - 1'b1;
                            state_nxt  = ST_WR_BURST;
                        end
                    end
                end
            end

            ST_WR_BURST: begin
                // Only data beats continue; a read from the granted master waits.
                ddr3_emif_write       = g_write;
                ddr3_emif_write_data  = g_wdata;
                ddr3_emif_byte_enable = g_be;
                wait_g                = ~(g_write & ddr3_emif_ready);
                if (g_write && ddr3_emif_ready) begin
                    wr_cnt_nxt = wr_cnt - 1'b1;
                    if (wr_cnt == ONE_BEAT) state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    assign m0_waitrequest = gnt  ? 1'b1 : wait_g;
    assign m1_waitrequest = !gnt ? 1'b1 : wait_g;

    always_ff @(posedge ddr3_emif_clk or posedge ddr3_emif_rst) begin
        if (ddr3_emif_rst) begin
            state  <= ST_IDLE;
            gnt    <= 1'b0;
            wr_cnt <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            wr_cnt <= wr_cnt_nxt;
        end
    end

    // ---------------- read return path ----------------
    assign tag_din = '{owner: gnt, burst: g_bc_eff};

    ddr3_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk   (ddr3_emif_clk),
        .rst   (ddr3_emif_rst),
        .push  (tag_push),
        .din   (tag_din),
        .pop   (tag_pop),
        .dout  (head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    assign head_last = (ret_cnt == head.burst - 1'b1);
    assign tag_pop   = ddr3_emif_rddata_valid & ~tag_empty & head_last;

    assign m0_readdata      = ddr3_emif_read_data;
    assign m1_readdata      = ddr3_emif_read_data;
    assign m0_readdatavalid = ddr3_emif_rddata_valid & ~tag_empty & ~head.owner;
    assign m1_readdatavalid = ddr3_emif_rddata_valid & ~tag_empty &  head.owner;

    always_ff @(posedge ddr3_emif_clk or posedge ddr3_emif_rst) begin
        if (ddr3_emif_rst) begin
            ret_cnt       <= '0;
            err_orphan_rd <= 1'b0;
        end else begin
            if (ddr3_emif_rddata_valid && !tag_empty) begin
                ret_cnt <= head_last ? '0 : ret_cnt + 1'b1;
            end
            if (ddr3_emif_rddata_valid && tag_empty) begin
                err_orphan_rd <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_emif_arbiter.sv
// Purpose: directed self-checking bench for ddr3_emif_arbiter (TAG_DEPTH = 8).
// Latency: inputs driven 1 ns after the rising edge, outputs sampled 1 ns later.
// Backpressure: EMIF ready toggled explicitly in the write-burst step.
module tb_ddr3_emif_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         m0_read, m0_write, m1_read, m1_write;
    logic [21:0]  m0_addr, m1_addr;
    logic [4:0]   m0_burstcount, m1_burstcount;
    logic [255:0] m0_writedata, m1_writedata;
    logic [31:0]  m0_byteenable, m1_byteenable;
    logic         m0_waitrequest, m1_waitrequest;
    logic [255:0] m0_readdata, m1_readdata;
    logic         m0_readdatavalid, m1_readdatavalid;
    logic         ready, rv;
    logic [255:0] rdata;
    logic         e_read, e_write;
    logic [21:0]  e_addr;
    logic [255:0] e_wdata;
    logic [31:0]  e_be;
    logic [4:0]   e_bc;
    logic         err;

    int total = 0;
    int bad   = 0;
    int wr_acc = 0;
    int wr_before;
    logic         exp_own;
    logic [255:0] exp_d;

    always #5 clk = ~clk;

    ddr3_emif_arbiter #(.TAG_DEPTH(8)) dut (
        .ddr3_emif_clk          (clk),
        .ddr3_emif_rst          (rst),
        .m0_read                (m0_read),
        .m0_write               (m0_write),
        .m0_addr                (m0_addr),
        .m0_burstcount          (m0_burstcount),
        .m0_writedata           (m0_writedata),
        .m0_byteenable          (m0_byteenable),
        .m0_waitrequest         (m0_waitrequest),
        .m0_readdata            (m0_readdata),
        .m0_readdatavalid       (m0_readdatavalid),
        .m1_read                (m1_read),
        .m1_write               (m1_write),
        .m1_addr                (m1_addr),
        .m1_burstcount          (m1_burstcount),
        .m1_writedata           (m1_writedata),
        .m1_byteenable          (m1_byteenable),
        .m1_waitrequest         (m1_waitrequest),
        .m1_readdata            (m1_readdata),
        .m1_readdatavalid       (m1_readdatavalid),
        .ddr3_emif_ready        (ready),
        .ddr3_emif_read_data    (rdata),
        .ddr3_emif_rddata_valid (rv),
        .ddr3_emif_read         (e_read),
        .ddr3_emif_write        (e_write),
        .ddr3_emif_addr         (e_addr),
        .ddr3_emif_write_data   (e_wdata),
        .ddr3_emif_byte_enable  (e_be),
        .ddr3_emif_burst_count  (e_bc),
        .err_orphan_rd          (err)
    );

    // Write beats actually taken by the EMIF.
    always @(posedge clk) begin
        if (!rst && e_write && ready) wr_acc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_read = 0; m0_write = 0; m0_addr = '0; m0_burstcount = '0;
        m0_writedata = '0; m0_byteenable = '0;
        m1_read = 0; m1_write = 0; m1_addr = '0; m1_burstcount = '0;
        m1_writedata = '0; m1_byteenable = '0;
        rv = 0; rdata = '0;
    endtask

    initial begin
        rst = 1'b1;
        ready = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_read", e_read, 0);
        chk("rst_write", e_write, 0);
        chk("rst_err", err, 0);
        chk("rst_rdv0", m0_readdatavalid, 0);
        rst = 1'b0;
        tick();

        // Both masters keep single-beat writes pending for three grants.
        m0_write = 1; m0_addr = 22'h0000A0; m0_burstcount = 1;
        m0_writedata = 256'hA0; m0_byteenable = '1;
        m1_write = 1; m1_addr = 22'h0000B1; m1_burstcount = 1;
        m1_writedata = 256'hB1; m1_byteenable = '1;
        #1;
        chk("arb_idle_nostrobe", e_write, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
`ifdef DDR3_ARB_FIXED_PRIO_EN
            exp_own = 1'b0;
`else
            exp_own = k[0];
`endif
            #1;
            chk("arb_addr", e_addr, exp_own ? 22'h0000B1 : 22'h0000A0);
            chk("arb_m0_wait", m0_waitrequest, exp_own ? 1 : 0);
            chk("arb_m1_wait", m1_waitrequest, exp_own ? 0 : 1);
            tick();
            #1;
            chk("arb_idle_after", e_write, 0);
        end
        clear_inputs();
        tick();

        // burstcount 0 is a single beat
        m0_write = 1; m0_addr = 22'h0000C0; m0_burstcount = 0; m0_byteenable = '1;
        tick();
        #1;
        chk("bc0_count", e_bc, 1);
        chk("bc0_write", e_write, 1);
        tick();
        #1;
        chk("bc0_back_idle", e_write, 0);
        m0_write = 0;
        tick();

        // m1 burst of 4 with ready low for 2 cycles, m0 read waiting
        m1_write = 1; m1_addr = 22'h000300; m1_burstcount = 4;
        m1_writedata = 256'hD0; m1_byteenable = 32'hFFFF_0000;
        wr_before = wr_acc;
        tick();
        m0_read = 1; m0_addr = 22'h000055; m0_burstcount = 1;
        #1;
        chk("wb_first_write", e_write, 1);
        chk("wb_addr", e_addr, 22'h000300);
        chk("wb_bc", e_bc, 4);
        chk("wb_be", e_be, 32'hFFFF_0000);
        chk("wb_m1_wait0", m1_waitrequest, 0);
        chk("wb_m0_wait0", m0_waitrequest, 1);
        tick();
        m1_writedata = 256'hD1;
        #1;
        chk("wb_data1", e_wdata, 256'hD1);
        chk("wb_no_read", e_read, 0);
        chk("wb_m0_wait1", m0_waitrequest, 1);
        tick();
        m1_writedata = 256'hD2; ready = 0;
        #1;
        chk("wb_stall_a", m1_waitrequest, 1);
        chk("wb_m0_wait2", m0_waitrequest, 1);
        tick();
        #1;
        chk("wb_stall_b", m1_waitrequest, 1);
        tick();
        ready = 1;
        #1;
        chk("wb_resume", m1_waitrequest, 0);
        chk("wb_data2", e_wdata, 256'hD2);
        chk("wb_m0_wait3", m0_waitrequest, 1);
        tick();
        m1_writedata = 256'hD3;
        #1;
        chk("wb_m0_wait4", m0_waitrequest, 1);
        tick();
        m1_write = 0;
        #1;
        chk("wb_done_idle", e_write, 0);
        chk("wb_beats", wr_acc - wr_before, 4);
        tick();
        #1;
        chk("rd0_read", e_read, 1);
        chk("rd0_addr", e_addr, 22'h000055);
        chk("rd0_wait", m0_waitrequest, 0);
        tick();
        m0_read = 0;
        rv = 1; rdata = 256'hBEEF;
        #1;
        chk("ret1_rdv0", m0_readdatavalid, 1);
        chk("ret1_rdv1", m1_readdatavalid, 0);
        chk("ret1_data", m0_readdata, 256'hBEEF);
        tick();
        rv = 0;

        // requester withdraws while granted
        m1_read = 1; m1_addr = 22'h000077; m1_burstcount = 1;
        tick();
        m1_read = 0;
        #1;
        chk("drop_nostrobe", e_read, 0);
        tick();
        m1_read = 1;
        #1;
        chk("drop_back_idle", e_read, 0);
        m1_read = 0;
        tick();

        // m0 burst 2 then m1 burst 3, five beats returned
        m0_read = 1; m0_addr = 22'h000010; m0_burstcount = 2;
        tick();
        tick();
        m0_read = 0;
        m1_read = 1; m1_addr = 22'h000020; m1_burstcount = 3;
        tick();
        #1;
        chk("rd1_addr", e_addr, 22'h000020);
        tick();
        m1_read = 0;
        for (int i = 0; i < 5; i++) begin
            exp_d = 256'h1000 + 256'(i);
            rv = 1; rdata = exp_d;
            #1;
            chk("route_rdv0", m0_readdatavalid, (i < 2) ? 1 : 0);
            chk("route_rdv1", m1_readdatavalid, (i >= 2) ? 1 : 0);
            chk("route_data1", m1_readdata, exp_d);
            tick();
        end
        rv = 0;
        #1;
        chk("route_no_err", err, 0);

        // fill the tag FIFO with 8 two-beat reads, ninth must wait
        m0_read = 1; m0_addr = 22'h000040; m0_burstcount = 2;
        for (int k = 0; k < 8; k++) begin
            tick();
            #1;
            chk("fill_wait", m0_waitrequest, 0);
            tick();
        end
        tick();
        #1;
        chk("full_wait", m0_waitrequest, 1);
        chk("full_no_read", e_read, 0);
        tick();
        rv = 1; rdata = 256'h4001;
        #1;
        chk("full_beat1", m0_readdatavalid, 1);
        chk("full_wait_b1", m0_waitrequest, 1);
        tick();
        #1;
        chk("full_beat2", m0_readdatavalid, 1);
        tick();
        rv = 0;
        #1;
        chk("full_release", m0_waitrequest, 0);
        chk("full_release_rd", e_read, 1);
        tick();
        m0_read = 0;
        for (int b = 0; b < 16; b++) begin
            rv = 1;
            #1;
            chk("drain_rdv0", m0_readdatavalid, 1);
            tick();
        end
        rv = 0;

        // orphan return
        rv = 1; rdata = 256'hDEAD;
        #1;
        chk("orphan_rdv0", m0_readdatavalid, 0);
        chk("orphan_rdv1", m1_readdatavalid, 0);
        tick();
        rv = 0;
        #1;
        chk("orphan_err", err, 1);

        // asynchronous reset in the middle of a write burst
        m0_write = 1; m0_addr = 22'h000090; m0_burstcount = 3; m0_byteenable = '1;
        tick();
        tick();
        #1;
        chk("arst_in_burst", e_write, 1);
        #2;
        rst = 1; rv = 1;
        #1;
        chk("arst_write", e_write, 0);
        chk("arst_m0_wait", m0_waitrequest, 1);
        chk("arst_m1_wait", m1_waitrequest, 1);
        chk("arst_err", err, 0);
        chk("arst_rdv0", m0_readdatavalid, 0);
        tick();
        rst = 0; m0_write = 0;
        #1;
        chk("post_rst_rdv0", m0_readdatavalid, 0);
        tick();
        rv = 0;
        #1;
        chk("post_rst_orphan", err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
